mips_lsu: RTL and testbench
===========================

Name: mips_lsu

Overview:
Load/store unit sitting directly downstream of the MIPS core datapath, between the core's ALU address output and the data memory port.
- Accepts one load or store request at a time from the core.
- Checks alignment and produces the word address, byte-lane write mask and lane-replicated store data.
- Waits on a variable-latency memory handshake, then returns sign- or zero-extended load data plus exception flags (AdEL, AdES, DBE) for the exception unit.

Parameters:
TIMEOUT, 16, cycles in ACCESS without mem_ack/mem_excpt before abort with DBE (legal 2..255)
CNT_W, 8, width of the timeout counter

Ports:
clk  input  1  clock, rising edge
rst_b  input  1  asynchronous active-low reset
req_valid  input  1  core requests an access this cycle
req_store  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word
req_signed  input  1  load sign-extends when 1
req_addr  input  32  byte address
req_wdata  input  32  store data (low-order bits significant)
busy  output  1  unit occupied; core must stall
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data, valid with resp_valid
excpt_adel  output  1  misaligned load, with resp_valid
excpt_ades  output  1  misaligned store, with resp_valid
excpt_dbe  output  1  bus error or timeout, with resp_valid
bad_addr  output  32  byte address of most recent faulting access
mem_req  output  1  memory access active
mem_addr  output  30  word address (addr[31:2])
mem_data_in  output  32  store data, lane-replicated
mem_write_en  output  4  byte write mask; 0 for loads
mem_ack  input  1  memory completed access
mem_data_out  input  32  read word, valid with mem_ack
mem_excpt  input  1  memory rejects address

Behaviour:
Reset (async, rst_b=0):
- state=IDLE.
- busy, resp_valid, all excpt_*, mem_req: 0.
- resp_rdata, bad_addr, mem_addr, mem_data_in, mem_write_en: 0.
- Reset mid-ACCESS aborts the access with no response.

FSM: IDLE, ACCESS. busy = (state==ACCESS).

IDLE, req_valid=1 in cycle T:
- Misaligned request (half with addr[0]=1, or word with addr[1:0]!=0): no memory access.
  - At T+1: resp_valid=1 and excpt_adel (load) or excpt_ades (store) =1, bad_addr=req_addr.
  - State stays IDLE.
- Aligned request: latch the request and go to ACCESS.
  - mem_req=1 from T+1 onward.
  - mem_addr, mem_data_in and mem_write_en are registered and held stable until the access completes.
  - Timeout counter is cleared.

ACCESS:
- Counter increments every cycle.
- mem_ack=1 in cycle T+k: next cycle resp_valid=1, mem_req=0, state=IDLE.
  - For loads, resp_rdata = extracted value.
- mem_excpt=1: same exit timing, excpt_dbe=1, bad_addr=latched address, resp_rdata=0.
- mem_ack and mem_excpt in the same cycle: excpt wins.
- Counter reaches TIMEOUT with no ack: same as mem_excpt.
- Minimum latency from accept to resp_valid is 2 cycles (ack at T+1).

Request acceptance:
- req_valid while busy is ignored; the core must hold it.
- A request in the cycle resp_valid is high is accepted (state is IDLE), allowing back-to-back accesses.
- resp_valid and excpt_* are single-cycle pulses.
- resp_rdata holds its value until the next response.
- bad_addr holds until the next fault.

Little-endian lanes (lane i = bits 8i+7:8i):
- Byte:
  - mem_write_en = 1<<addr[1:0].
  - mem_data_in = {4{wdata[7:0]}}.
  - Load takes lane addr[1:0].
- Half:
  - mem_write_en = addr[1] ? 1100 : 0011.
  - mem_data_in = {2{wdata[15:0]}}.
  - Load takes upper half if addr[1]=1, else lower half.
- Word: mem_write_en = 1111, data passed through unchanged.
- Loads always have mem_write_en = 0000.
- Load extension: req_signed=1 replicates the top bit of the extracted field; req_signed=0 fills with zeros.
- Stores return resp_rdata unchanged and raise no load data.

Test Plan:
- Load word at 0x10000004, signed=0; mem returns 0xDEADBEEF with ack at T+3 → mem_addr=0x04000001, write_en=0000, busy high T+1..T+3, resp_valid at T+4, rdata=0xDEADBEEF.
- Store byte 0x000000A5 at 0x10000002 → write_en=0100, mem_data_in=0xA5A5A5A5; ack at T+1 → resp_valid at T+2 with no excpt.
- Signed load half at 0x10000006, mem word 0x8001_1234 → rdata=0xFFFF8001; same access with signed=0 → rdata=0x00008001.
- Load word at 0x10000002 → no mem_req, resp_valid and excpt_adel at T+1, bad_addr=0x10000002; store half at 0x10000001 → excpt_ades.
- Aligned load, mem never acks, TIMEOUT=16 → excpt_dbe with resp_valid 17 cycles after accept, mem_req drops; separately, mem_ack+mem_excpt in the same cycle → excpt_dbe=1.
- rst_b pulsed low during ACCESS → mem_req, busy and all outputs 0 immediately, no resp_valid; after release, a new request completes normally; a back-to-back request issued in the cycle resp_valid is high is accepted.

Source files
------------

// File: rtl/mips_lsu.sv
`default_nettype none
// ============================================================================
// mips_lsu : MIPS load/store unit - alignment check, lane steering,
//            variable-latency memory handshake with timeout, load extension.
// Rev 1.0
// ============================================================================
module mips_lsu #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        req_valid,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        excpt_adel,
    output logic        excpt_ades,
    output logic        excpt_dbe,
    output logic [31:0] bad_addr,
    output logic        mem_req,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_data_in,
    output logic [3:0]  mem_write_en,
    input  logic        mem_ack,
    input  logic [31:0] mem_data_out,
    input  logic        mem_excpt
);

    typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state;
    logic              store_q;
    logic              signed_q;
    logic [1:0]        size_q;
    logic [31:0]       addr_q;
    logic [CNT_W-1:0]  cnt;

    logic              misaligned;
    logic [3:0]        lane_mask;
    logic [31:0]       lane_data;
    logic [31:0]       load_val;
    logic              abort;

    assign busy = (state == ACCESS);

    // Size 11 behaves exactly like a word access.
    always_comb begin
        misaligned = 1'b0;
        lane_mask  = 4'b1111;
        lane_data  = req_wdata;
        case (req_size)
            2'b00: begin
                lane_mask = 4'b0001 << req_addr[1:0];
                lane_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = req_addr[0];
                lane_mask  = req_addr[1] ? 4'b1100 : 4'b0011;
                lane_data  = {2{req_wdata[15:0]}};
            end
            default: begin
                misaligned = (req_addr[1:0] != 2'b00);
            end
        endcase
    end

    always_comb begin
        load_val = mem_data_out;
        case (size_q)
            2'b00: begin
                case (addr_q[1:0])
                    2'b00:   load_val = {{24{signed_q & mem_data_out[7]}},  mem_data_out[7:0]};
                    2'b01:   load_val = {{24{signed_q & mem_data_out[15]}}, mem_data_out[15:8]};
                    2'b10:   load_val = {{24{signed_q & mem_data_out[23]}}, mem_data_out[23:16]};
                    default: load_val = {{24{signed_q & mem_data_out[31]}}, mem_data_out[31:24]};
                endcase
            end
            2'b01: begin
                if (addr_q[1])
                    load_val = {{16{signed_q & mem_data_out[31]}}, mem_data_out[31:16]};
                else
                    load_val = {{16{signed_q & mem_data_out[15]}}, mem_data_out[15:0]};
            end
            default: load_val = mem_data_out;
        endcase
    end

    // A bus error or an expired timeout both terminate with DBE; an ack on the
    // final counted cycle still completes normally.
    assign abort = mem_excpt || (!mem_ack && (cnt == CNT_LAST));

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state        <= IDLE;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            excpt_adel   <= 1'b0;
            excpt_ades   <= 1'b0;
            excpt_dbe    <= 1'b0;
            bad_addr     <= '0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            mem_data_in  <= '0;
            mem_write_en <= '0;
            store_q      <= 1'b0;
            signed_q     <= 1'b0;
            size_q       <= '0;
            addr_q       <= '0;
            cnt          <= '0;
        end else begin
            resp_valid <= 1'b0;
            excpt_adel <= 1'b0;
            excpt_ades <= 1'b0;
            excpt_dbe  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (misaligned) begin
                            resp_valid <= 1'b1;
                            excpt_adel <= !req_store;
                            excpt_ades <= req_store;
                            bad_addr   <= req_addr;
                        end else begin
                            state        <= ACCESS;
                            mem_req      <= 1'b1;
                            mem_addr     <= req_addr[31:2];
                            mem_data_in  <= lane_data;
                            mem_write_en <= req_store ? lane_mask : 4'b0000;
                            store_q      <= req_store;
                            signed_q     <= req_signed;
                            size_q       <= req_size;
                            addr_q       <= req_addr;
                            cnt          <= '0;
                        end
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (abort) begin
                        state      <= IDLE;
                        mem_req    <= 1'b0;
                        resp_valid <= 1'b1;
                        excpt_dbe  <= 1'b1;
                        bad_addr   <= addr_q;
                        resp_rdata <= '0;
                    end else if (mem_ack) begin
                        state      <= IDLE;
                        mem_req    <= 1'b0;
                        resp_valid <= 1'b1;
                        if (!store_q)
                            resp_rdata <= load_val;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_lsu.sv
`default_nettype none
// Self-checking bench for mips_lsu: directed plan scenarios plus randomized
// accesses checked against an arithmetic reference model.
module tb_mips_lsu;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_store = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        busy, resp_valid, excpt_adel, excpt_ades, excpt_dbe, mem_req;
    logic [31:0] resp_rdata, bad_addr, mem_data_in;
    logic [29:0] mem_addr;
    logic [3:0]  mem_write_en;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_data_out = '0;
    logic        mem_excpt = 1'b0;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_rdata = '0;
    logic [31:0] exp_bad = '0;

    mips_lsu #(.TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk(clk), .rst_b(rst_b),
        .req_valid(req_valid), .req_store(req_store), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .excpt_adel(excpt_adel), .excpt_ades(excpt_ades), .excpt_dbe(excpt_dbe),
        .bad_addr(bad_addr), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_write_en(mem_write_en),
        .mem_ack(mem_ack), .mem_data_out(mem_data_out), .mem_excpt(mem_excpt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg,
                                             input logic [31:0] a, input logic [31:0] w);
        longint v;
        if (sz == 2'd0) begin
            v = (longint'(w) >> (8 * (a % 4))) % 256;
            if (sg && v >= 128) v = v - 256;
        end else if (sz == 2'd1) begin
            v = (longint'(w) >> (16 * ((a / 2) % 2))) % 65536;
            if (sg && v >= 32768) v = v - 65536;
        end else begin
            v = longint'(w);
        end
        return v[31:0];
    endfunction

    function automatic logic [3:0] ref_we(input logic st, input logic [1:0] sz, input logic [31:0] a);
        int m;
        if (!st) m = 0;
        else if (sz == 2'd0) m = 1 << (a % 4);
        else if (sz == 2'd1) m = ((a % 4) >= 2) ? 12 : 3;
        else m = 15;
        return m[3:0];
    endfunction

    function automatic logic [31:0] ref_wd(input logic [1:0] sz, input logic [31:0] d);
        longint v;
        if (sz == 2'd0) v = (longint'(d) % 256) * 64'h01010101;
        else if (sz == 2'd1) v = (longint'(d) % 65536) * 64'h00010001;
        else v = longint'(d);
        return v[31:0];
    endfunction

    function automatic bit ref_misaligned(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd1) return (a % 2) != 0;
        if (sz >= 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    // Called at the start of a cycle (posedge+1); issues the request in that cycle,
    // answers memory in cycle T+d, checks the response at T+d+1 and returns there.
    task automatic do_access(input logic st, input logic [1:0] sz, input logic sg,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] mw, input int d,
                             input logic ack, input logic ex, input string nm);
        bit mis;
        mis = ref_misaligned(sz, a);
        req_valid = 1'b1; req_store = st; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom;
        if (mis) begin
            exp_bad = a;
            tests++;
            if (resp_valid !== 1'b1 || excpt_adel !== !st || excpt_ades !== st ||
                excpt_dbe !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL %s misaligned flags: rv=%b adel=%b ades=%b dbe=%b mreq=%b busy=%b, need rv=1 adel=%b ades=%b",
                         nm, resp_valid, excpt_adel, excpt_ades, excpt_dbe, mem_req, busy, !st, st);
            end
            tests++;
            if (bad_addr !== exp_bad) begin
                fails++;
                $display("FAIL %s bad_addr: got %h need %h", nm, bad_addr, exp_bad);
            end
            return;
        end
        tests++;
        if (busy !== 1'b1 || mem_req !== 1'b1 || resp_valid !== 1'b0 ||
            mem_addr !== a[31:2] || mem_write_en !== ref_we(st, sz, a) ||
            (st && mem_data_in !== ref_wd(sz, wd))) begin
            fails++;
            $display("FAIL %s issue: busy=%b mreq=%b rv=%b addr=%h we=%b din=%h need addr=%h we=%b din=%h",
                     nm, busy, mem_req, resp_valid, mem_addr, mem_write_en, mem_data_in,
                     a[31:2], ref_we(st, sz, a), ref_wd(sz, wd));
        end
        for (int i = 1; i < d; i++) begin
            @(posedge clk); #1;
            tests++;
            if (busy !== 1'b1 || resp_valid !== 1'b0 || mem_addr !== a[31:2] ||
                mem_write_en !== ref_we(st, sz, a)) begin
                fails++;
                $display("FAIL %s wait T+%0d: busy=%b rv=%b addr=%h we=%b", nm, i + 1,
                         busy, resp_valid, mem_addr, mem_write_en);
            end
        end
        mem_ack = ack; mem_excpt = ex; mem_data_out = mw;
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_excpt = 1'b0; mem_data_out = $urandom;
        if (ex) begin
            exp_rdata = '0;
            exp_bad = a;
        end else if (!st) begin
            exp_rdata = ref_load(sz, sg, a, mw);
        end
        tests++;
        if (resp_valid !== 1'b1 || excpt_dbe !== ex || excpt_adel !== 1'b0 ||
            excpt_ades !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s response: rv=%b dbe=%b adel=%b ades=%b mreq=%b busy=%b need rv=1 dbe=%b",
                     nm, resp_valid, excpt_dbe, excpt_adel, excpt_ades, mem_req, busy, ex);
        end
        tests++;
        if (resp_rdata !== exp_rdata || bad_addr !== exp_bad) begin
            fails++;
            $display("FAIL %s rdata/bad_addr: got %h/%h need %h/%h", nm, resp_rdata,
                     bad_addr, exp_rdata, exp_bad);
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        #12;
        tests++;
        if (busy !== 0 || resp_valid !== 0 || excpt_adel !== 0 || excpt_ades !== 0 ||
            excpt_dbe !== 0 || mem_req !== 0 || resp_rdata !== 0 || bad_addr !== 0 ||
            mem_addr !== 0 || mem_data_in !== 0 || mem_write_en !== 0) begin
            fails++;
            $display("FAIL reset_state: busy=%b rv=%b mreq=%b rdata=%h bad=%h addr=%h din=%h we=%b, need all 0",
                     busy, resp_valid, mem_req, resp_rdata, bad_addr, mem_addr, mem_data_in, mem_write_en);
        end
        @(negedge clk); rst_b = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        do_access(1'b0, 2'd2, 1'b0, 32'h1000_0004, 32'h0, 32'hDEAD_BEEF, 3, 1'b1, 1'b0, "lw");
        @(posedge clk); #1;
        do_access(1'b1, 2'd0, 1'b0, 32'h1000_0002, 32'h0000_00A5, 32'h0, 1, 1'b1, 1'b0, "sb");
        @(posedge clk); #1;
        do_access(1'b0, 2'd1, 1'b1, 32'h1000_0006, 32'h0, 32'h8001_1234, 2, 1'b1, 1'b0, "lh_signed");
        do_access(1'b0, 2'd1, 1'b0, 32'h1000_0006, 32'h0, 32'h8001_1234, 2, 1'b1, 1'b0, "lhu");
        tests++;
        if (resp_rdata !== 32'h0000_8001) begin
            fails++;
            $display("FAIL lhu_value: got %h need 00008001", resp_rdata);
        end
    endtask

    task automatic test_misaligned();
        @(posedge clk); #1;
        do_access(1'b0, 2'd2, 1'b0, 32'h1000_0002, 32'h0, 32'h0, 1, 1'b1, 1'b0, "lw_mis");
        @(posedge clk); #1;
        tests++;
        if (resp_valid !== 1'b0 || excpt_adel !== 1'b0 || bad_addr !== 32'h1000_0002) begin
            fails++;
            $display("FAIL adel_pulse: rv=%b adel=%b bad=%h need 0 0 10000002",
                     resp_valid, excpt_adel, bad_addr);
        end
        do_access(1'b1, 2'd1, 1'b0, 32'h1000_0001, 32'h1234, 32'h0, 1, 1'b1, 1'b0, "sh_mis");
        do_access(1'b1, 2'd3, 1'b0, 32'h2000_0003, 32'h1234, 32'h0, 1, 1'b1, 1'b0, "s11_mis");
    endtask

    task automatic test_timeout();
        int cyc;
        @(posedge clk); #1;
        req_valid = 1'b1; req_store = 1'b0; req_size = 2'd2; req_addr = 32'h3000_0010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 1;
        while (resp_valid !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        exp_rdata = '0; exp_bad = 32'h3000_0010;
        tests++;
        if (cyc != TMO + 1 || excpt_dbe !== 1'b1 || mem_req !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL timeout: resp after %0d cycles dbe=%b mreq=%b busy=%b, need %0d cycles dbe=1",
                     cyc, excpt_dbe, mem_req, busy, TMO + 1);
        end
        tests++;
        if (resp_rdata !== exp_rdata || bad_addr !== exp_bad) begin
            fails++;
            $display("FAIL timeout_data: rdata=%h bad=%h need %h %h", resp_rdata, bad_addr, exp_rdata, exp_bad);
        end
        @(posedge clk); #1;
        do_access(1'b0, 2'd2, 1'b0, 32'h4000_0020, 32'h0, 32'h5555_AAAA, 4, 1'b1, 1'b1, "ack_and_excpt");
        do_access(1'b0, 2'd2, 1'b0, 32'h4000_0024, 32'h0, 32'h1357_9BDF, TMO, 1'b1, 1'b0, "ack_last_cycle");
    endtask

    task automatic test_reset_mid_access();
        @(posedge clk); #1;
        req_valid = 1'b1; req_store = 1'b1; req_size = 2'd2;
        req_addr = 32'h5000_0008; req_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #3;
        rst_b = 1'b0;
        #1;
        exp_rdata = '0; exp_bad = '0;
        tests++;
        if (busy !== 0 || mem_req !== 0 || mem_addr !== 0 || mem_write_en !== 0 ||
            mem_data_in !== 0 || resp_rdata !== 0 || bad_addr !== 0) begin
            fails++;
            $display("FAIL reset_mid_access: busy=%b mreq=%b addr=%h we=%b din=%h, need all 0",
                     busy, mem_req, mem_addr, mem_write_en, mem_data_in);
        end
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        tests++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_no_resp: rv=%b busy=%b need 0 0", resp_valid, busy);
        end
        @(negedge clk); rst_b = 1'b1;
        @(posedge clk); #1;
        do_access(1'b0, 2'd0, 1'b1, 32'h5000_0003, 32'h0, 32'h80FF_0000, 2, 1'b1, 1'b0, "post_reset_lb");
    endtask

    task automatic test_back_to_back();
        do_access(1'b1, 2'd1, 1'b0, 32'h6000_0002, 32'hABCD_1234, 32'h0, 1, 1'b1, 1'b0, "b2b_sh");
        do_access(1'b0, 2'd0, 1'b0, 32'h6000_0001, 32'h0, 32'h0000_9F00, 1, 1'b1, 1'b0, "b2b_lbu");
        do_access(1'b0, 2'd2, 1'b0, 32'h6000_0008, 32'h0, 32'h0BAD_CAFE, 2, 1'b1, 1'b0, "b2b_lw");
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [1:0]  sz;
        int          d;
        bit          ex;
        for (int n = 0; n < 60; n++) begin
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                else if (sz != 2'd0) a[1:0] = 2'b00;
            end
            d  = $urandom_range(1, 8);
            ex = ($urandom_range(0, 7) == 0);
            do_access(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom, d,
                      ~ex | 1'($urandom), ex, "random");
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_misaligned();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
